// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: NOP_INSTR, FETCH_DEPTH_DEFAULT, fetch_state_e {BOOT, RUN},
//           fetch_entry_t {pc, instr}.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR           = 32'h0000_0013;
  localparam int          FETCH_DEPTH_DEFAULT = 4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t with flush; head is read straight from storage.
// Latency: a pushed entry becomes visible at the head on the cycle after the push.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
// Ports: clk/rst_n (async active-low), push/push_data, pop, flush, head, count, full, empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = FETCH_DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues word fetches over req/gnt/rvalid and buffers instructions for decode.
// Latency: rvalid -> if_valid_o is 1 cycle (0 cycles via the bypass when FETCH_BYPASS_EN is defined).
// Backpressure: issue stalls while outstanding + buffered fetches reach FIFO_DEPTH; a redirect flushes.
// Ports: clk_i, rst_n_i (async active-low), redirect_i/redirect_pc_i from execute,
//        imem_req_o/imem_addr_o/imem_gnt_i/imem_rvalid_i/imem_rdata_i to instruction memory,
//        if_valid_o/if_ready_i/if_pc_o/if_pc_next_o/if_instr_o to the IF/DE register.
// Optional macro: FETCH_BYPASS_EN forwards a response combinationally when the buffer is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          FIFO_DEPTH = FETCH_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_next_o,
  output logic [31:0] if_instr_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] pcq_cnt;
  logic [CW:0]   in_flight;
  logic          fifo_full, fifo_empty, pcq_full, pcq_empty;
  fetch_entry_t  fifo_head, fifo_wdata, pcq_head, pcq_wdata, present;
  logic          accept, resp, drop, fifo_push, fifo_pop, pcq_pop;

  // Credit check uses the registered counts only, so a pop this cycle does not free a slot yet.
  assign in_flight  = {1'b0, out_cnt} + {1'b0, fifo_cnt};
  assign imem_req_o = (state == RUN) && !redirect_i && (in_flight < (CW+1)'(FIFO_DEPTH));
  assign imem_addr_o = fetch_pc;
  assign accept     = imem_req_o && imem_gnt_i;

  // Responses with nothing outstanding (e.g. in flight across a reset) are ignored.
  assign resp     = imem_rvalid_i && (out_cnt != '0);
  assign drop     = (discard_cnt != '0) || redirect_i;
  // Stale responses were never re-queued after the flush, so only kept ones pop the PC queue.
  assign pcq_pop  = resp && !drop;
  assign fifo_pop = if_valid_o && if_ready_i && !redirect_i;

  assign pcq_wdata  = {fetch_pc, 32'h0000_0000};
  assign fifo_wdata = {pcq_head.pc, imem_rdata_i};

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass     = resp && !drop && fifo_empty;
  assign fifo_push  = resp && !drop && !(bypass && if_ready_i);
  assign present    = bypass ? fifo_wdata : fifo_head;
  assign if_valid_o = !fifo_empty || bypass;
`else
  assign fifo_push  = resp && !drop;
  assign present    = fifo_head;
  assign if_valid_o = !fifo_empty;
`endif

  assign if_pc_o      = if_valid_o ? present.pc : 32'h0000_0000;
  assign if_pc_next_o = if_pc_o + 32'd4;
  assign if_instr_o   = if_valid_o ? present.instr : NOP_INSTR;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      out_cnt     <= '0;
      discard_cnt <= '0;
    end else begin
      if (state == BOOT) state <= RUN;

      if (redirect_i)  fetch_pc <= redirect_pc_i;
      else if (accept) fetch_pc <= fetch_pc + 32'd4;

      out_cnt <= out_cnt + CW'(accept) - CW'(resp);

      // Everything still outstanding once this cycle's response retires is stale.
      if (redirect_i)                         discard_cnt <= out_cnt - CW'(resp);
      else if (resp && (discard_cnt != '0))   discard_cnt <= discard_cnt - CW'(1);
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_instr_fifo (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .flush     (redirect_i),
    .head      (fifo_head),
    .count     (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Pairs each outstanding request with its address; the instr field is unused here.
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .push      (accept),
    .push_data (pcq_wdata),
    .pop       (pcq_pop),
    .flush     (redirect_i),
    .head      (pcq_head),
    .count     (pcq_cnt),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

  logic unused_status;
  assign unused_status = ^{pcq_cnt, pcq_full, pcq_empty, pcq_head.instr, fifo_full};

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench with an in-order memory model, a program-order reference
// and a scoreboard queue of expected {pc, instr} deliveries checked by a separate monitor.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk, rst_n, redirect, gnt, rvalid, ready;
  logic [31:0] redirect_pc, rdata, addr, if_pc, if_pc_next, if_instr;
  logic        req, if_valid;

  fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .if_valid_o    (if_valid),
    .if_ready_i    (ready),
    .if_pc_o       (if_pc),
    .if_pc_next_o  (if_pc_next),
    .if_instr_o    (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Memory model: in-order responses, latency >= 1, tagged with the program epoch at accept.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t        mem_q[$];
  fetch_entry_t exp_q[$];
  int           epoch = 0, cyc = 0, last_due = 0, n_acc = 0;
  logic [31:0]  exp_fetch_pc = RPC;
  int           gnt_pct, rdy_pct, redir_pct, lat_min, lat_max;
  bit           force_redir = 0, prev_hold = 0, prev_redir = 0;
  logic [31:0]  force_pc = 0, prev_addr = 0, held;
  int           acc_before;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
  endfunction

  task automatic set_knobs(input int g, input int r, input int rd, input int lmin, input int lmax);
    gnt_pct = g; rdy_pct = r; redir_pct = rd; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"},     32'(req), 0);
    chk({tag, "_addr"},    addr, RPC);
    chk({tag, "_valid"},   32'(if_valid), 0);
    chk({tag, "_pc"},      if_pc, 0);
    chk({tag, "_pc_next"}, if_pc_next, 32'd4);
    chk({tag, "_instr"},   if_instr, NOP_INSTR);
  endtask

  // One clock cycle: drive inputs just after the rising edge, observe the request at the falling edge.
  task automatic step();
    mreq_t        m;
    fetch_entry_t fe;
    int           d;
    @(posedge clk);
    #1;
    cyc++;
    redirect    = 1'b0;
    redirect_pc = $urandom & 32'hFFFF_FFFC;
    if (force_redir || (!prev_redir && ($urandom_range(99) < redir_pct))) begin
      redirect = 1'b1;
      if (force_redir) redirect_pc = force_pc;
      force_redir  = 0;
      epoch++;
      exp_q.delete();
      exp_fetch_pc = redirect_pc;
    end
    prev_redir = redirect;
    rvalid = 1'b0;
    rdata  = $urandom;
    if ((mem_q.size() > 0) && (mem_q[0].due <= cyc)) begin
      m      = mem_q.pop_front();
      rvalid = 1'b1;
      rdata  = mem_word(m.addr);
      if (m.epoch == epoch) begin
        fe.pc    = m.addr;
        fe.instr = rdata;
        exp_q.push_back(fe);
      end
    end
    gnt   = ($urandom_range(99) < gnt_pct);
    ready = ($urandom_range(99) < rdy_pct);
    @(negedge clk);
    if (redirect) chk("no_req_on_redirect", 32'(req), 0);
    else if (prev_hold) begin
      chk("hold_req", 32'(req), 1);
      chk("hold_addr", addr, prev_addr);
    end
    prev_hold = req && !gnt;
    prev_addr = addr;
    if (req && gnt) begin
      chk("fetch_addr", addr, exp_fetch_pc);
      exp_fetch_pc = exp_fetch_pc + 32'd4;
      n_acc++;
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      m.addr  = addr;
      m.epoch = epoch;
      m.due   = d;
      mem_q.push_back(m);
    end
  endtask

  // Monitor: every transfer to decode must be the next expected program-order instruction.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (rst_n === 1'b1) begin
      if (!if_valid) chk("idle_nop", if_instr, NOP_INSTR);
      else if (ready && !redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc %h expected no transfer", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("if_pc", if_pc, e.pc);
          chk("if_instr", if_instr, e.instr);
          chk("if_pc_next", if_pc_next, e.pc + 32'd4);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; gnt = 1'b0;
    rvalid = 1'b0; rdata = '0; ready = 1'b0;
    set_knobs(100, 100, 0, 1, 1);
    repeat (2) @(negedge clk);
    check_reset("reset");

    // Reset release: one idle BOOT cycle, then back-to-back fetches from RESET_PC.
    @(posedge clk); #1; rst_n = 1'b1; gnt = 1'b1; ready = 1'b1;
    @(negedge clk); chk("boot_no_req", 32'(req), 0);
    step(); chk("first_req", 32'(req), 1); chk("first_addr", addr, RPC);
    step(); chk("first_rvalid", 32'(rvalid), 1); chk("valid_not_before_latency", 32'(if_valid), 0);
    step(); chk("valid_after_rvalid", 32'(if_valid), 1); chk("first_if_pc", if_pc, RPC);
    chk("three_consecutive_accepts", n_acc, 3);

    set_knobs(80, 70, 0, 1, 3);
    repeat (300) step();

    // Decode stall: buffer fills to DEPTH and issue stops.
    set_knobs(100, 0, 0, 1, 1);
    repeat (12) step();
    chk("stall_req_low", 32'(req), 0);
    chk("stall_valid", 32'(if_valid), 1);
    chk("stall_buffered", exp_q.size(), DEPTH);
    chk("stall_outstanding", mem_q.size(), 0);
    set_knobs(100, 100, 0, 1, 1);
    repeat (10) step();

    // Three outstanding with long latency, then redirect to 0x100.
    set_knobs(0, 100, 0, 1, 1);
    repeat (6) step();
    set_knobs(100, 100, 0, 5, 5);
    repeat (3) step();
    chk("three_outstanding", mem_q.size(), 3);
    force_pc = 32'h0000_0100; force_redir = 1;
    step();
    step(); chk("redir_next_req", 32'(req), 1); chk("redir_next_addr", addr, 32'h0000_0100);
    set_knobs(100, 100, 0, 1, 2);
    repeat (20) step();

    // Redirect coinciding with a response and a decode pop.
    set_knobs(100, 100, 0, 1, 1);
    repeat (8) step();
    force_pc = 32'h0000_0200; force_redir = 1;
    step(); chk("redir_same_rvalid", 32'(rvalid), 1); chk("redir_same_valid", 32'(if_valid), 1);
    step(); chk("redir2_next_req", 32'(req), 1); chk("redir2_next_addr", addr, 32'h0000_0200);
    repeat (4) step();

    // Grant withheld for 5 cycles: address must hold, exactly one accept when it rises.
    set_knobs(0, 100, 0, 1, 1);
    step(); held = addr; chk("gnt_stall_req", 32'(req), 1);
    repeat (4) begin step(); chk("gnt_stall_addr", addr, held); end
    set_knobs(100, 100, 0, 1, 1);
    acc_before = n_acc;
    step(); chk("gnt_single_accept", n_acc - acc_before, 1);
    step(); chk("gnt_next_addr", addr, held + 32'd4);

    // PC wrap at 2^32.
    set_knobs(90, 90, 0, 1, 2);
    force_pc = 32'hFFFF_FFF8; force_redir = 1;
    repeat (30) step();

    // Reset in the middle of traffic.
    set_knobs(100, 0, 0, 3, 3);
    repeat (4) step();
    @(posedge clk); #1;
    rst_n = 1'b0; redirect = 1'b0; rvalid = 1'b0; gnt = 1'b0; ready = 1'b0;
    mem_q.delete(); exp_q.delete(); epoch++;
    exp_fetch_pc = RPC; prev_hold = 0; prev_redir = 0;
    @(negedge clk); check_reset("midrst");
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); chk("midrst_boot_no_req", 32'(req), 0);
    set_knobs(100, 100, 0, 1, 1);
    step(); chk("restart_req", 32'(req), 1); chk("restart_addr", addr, RPC);

    // Random traffic with redirects.
    set_knobs(75, 75, 4, 1, 4);
    repeat (500) step();

    // Drain: every fresh response must have reached decode.
    set_knobs(0, 100, 0, 1, 1);
    repeat (25) step();
    chk("drain_all_delivered", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end that owns the program counter, issues word fetches to instruction memory over a request/grant/response handshake, and buffers returned instructions in a small FIFO. It feeds the IF/DE pipeline register with {pc, pc+4, instr} under a valid/ready handshake. It absorbs decode stalls and variable memory latency, and flushes cleanly on a taken branch/jump redirect from the execute stage.

## Interface
- FIFO_DEPTH, 4: instruction buffer entries; also the maximum outstanding plus buffered fetches. Power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- redirect_i  in  1  taken branch/jump from execute; single-cycle pulse.
- redirect_pc_i  in  32  redirect target; word-aligned.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch address (current fetch PC).
- imem_gnt_i  in  1  request accepted this cycle when imem_req_o && imem_gnt_i.
- imem_rvalid_i  in  1  response valid; responses return in order, latency ≥1 cycle.
- imem_rdata_i  in  32  instruction word.
- if_valid_o  out  1  instruction available to decode.
- if_ready_i  in  1  decode accepts; transfer occurs when if_valid_o && if_ready_i.
- if_pc_o  out  32  PC of the presented instruction.
- if_pc_next_o  out  32  if_pc_o + 4, modulo 2^32.
- if_instr_o  out  32  instruction; 32'h0000_0013 (NOP) whenever if_valid_o = 0.

## Operation
- FSM states:
  - BOOT: entered on reset. Holds imem_req_o = 0 for one cycle, then moves to RUN.
  - RUN: normal operation. Stays in RUN until the next reset.
- Counters:
  - fetch_pc: reset RESET_PC.
  - out_cnt: accepted, unreturned requests.
  - fifo_cnt: buffered entries.
  - discard_cnt: responses still to drop.
  - A PC queue of depth FIFO_DEPTH pairs each outstanding request with its address.
- Issue:
  - imem_req_o = RUN && !redirect_i && (out_cnt + fifo_cnt < FIFO_DEPTH).
  - A same-cycle FIFO pop earns no credit.
  - On accept, fetch_pc += 4 (wraps at 2^32) and out_cnt increments.
  - imem_addr_o must be held stable while imem_req_o = 1 and imem_gnt_i = 0.
- Response:
  - Each imem_rvalid_i decrements out_cnt.
  - If discard_cnt > 0 or redirect_i is high, the response is dropped and discard_cnt decrements when nonzero.
  - Otherwise {queued pc, rdata} is pushed to the FIFO.
- Redirect, on the redirect_i cycle:
  - fetch_pc ← redirect_pc_i.
  - FIFO and PC queue cleared; any same-cycle pop is ignored.
  - discard_cnt ← out_cnt after this cycle's response has retired.
  - No request is issued.
  - if_valid_o = 0 from the next cycle until the first post-redirect instruction arrives.
- Simultaneous push and pop with a non-empty FIFO: fifo_cnt is unchanged.
- A full FIFO with if_ready_i = 0 stalls issue via the capacity rule. Overflow is impossible by construction.
- A reset assertion mid-operation clears all state asynchronously. In-flight responses arriving after rst_n_i deasserts are dropped because out_cnt = 0.

## Timing
- Reset values:
  - imem_req_o = 0, imem_addr_o = RESET_PC.
  - if_valid_o = 0, if_pc_o = 0, if_pc_next_o = 4, if_instr_o = NOP.
  - All counters 0, FSM = BOOT.
- First request is asserted on the second cycle after reset deassertion.
- Outputs to decode are registered at the FIFO head. Latency from imem_rvalid_i to if_valid_o is 1 cycle (see Configuration).
- Sustained throughput with single-cycle memory and if_ready_i = 1 is one instruction per cycle.
- Redirect to first request at the new PC is 1 cycle. The redirect_i → imem_req_o path is combinational.

## Configuration
- FETCH_BYPASS_EN
  - Defined: when the FIFO is empty and no discard is pending, a valid response is forwarded combinationally to if_* in the same cycle. It is pushed only if if_ready_i = 0. Latency is 0 cycles.
  - Undefined: every response goes through the FIFO. Latency is 1 cycle and there are no combinational paths from imem_* to if_*.

## Structure
- fetch_pkg holds:
  - NOP_INSTR = 32'h0000_0013.
  - fetch_state_e {BOOT, RUN}.
  - fetch_entry_t {pc[31:0], instr[31:0]}.
  - FETCH_DEPTH_DEFAULT.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, full and empty, parameterised by FIFO_DEPTH. The PC queue reuses it.

## Test plan
- Reset release, 1-cycle memory, if_ready_i = 1 → requests at 0x0, 0x4, 0x8 on consecutive cycles. if_pc_o is 0x0, 0x4, 0x8 one cycle after each rvalid, with if_pc_next_o = if_pc_o + 4.
- if_ready_i = 0 for 10 cycles → exactly 4 entries buffered, imem_req_o low while out_cnt + fifo_cnt = 4. On release, instructions drain in order with no loss or duplication.
- 3 requests outstanding (3-cycle latency), then redirect_i with redirect_pc_i = 0x100 → all 3 stale responses dropped. The next if_pc_o = 0x100 and no PC < 0x100 is ever presented.
- redirect_i in the same cycle as imem_rvalid_i and an if_ready_i pop → that response is dropped, the pop is ignored, and the next request address is the redirect target.
- gnt held low for 5 cycles → imem_addr_o stable across the stall, with one accept once gnt rises.
- Reset asserted with 2 outstanding and 2 buffered → next cycle all outputs are at reset values, and post-reset fetch restarts at RESET_PC.
